axil_reg_slave: RTL and testbench
=================================

Name: axil_reg_slave

Overview:
AXI4-Lite responder exposing REG_COUNT 32-bit read/write registers to an AXI-Lite initiator such as the CPU's load/store unit. It accepts AW and W independently and in either order, and applies byte strobes. It returns OKAY or SLVERR per access. Register contents are exported as a flat bus so peripherals such as LEDs, a timer and control bits can consume them directly.

Parameters:
ADDR_WIDTH, 16, byte-address width of araddr/awaddr.
DATA_WIDTH, 32, data width; only 32 is supported.
REG_COUNT, 8, number of RW registers; word index 0..REG_COUNT-1.

Ports:
i_Clock  in  1  clock
i_Reset  in  1  reset, asynchronous, active-low
s_axil_awaddr  in  ADDR_WIDTH  write address
s_axil_awvalid  in  1  write address valid
s_axil_awready  out  1  write address ready
s_axil_wdata  in  32  write data
s_axil_wstrb  in  4  byte strobes
s_axil_wvalid  in  1  write data valid
s_axil_wready  out  1  write data ready
s_axil_bresp  out  2  write response
s_axil_bvalid  out  1  write response valid
s_axil_bready  in  1  write response ready
s_axil_araddr  in  ADDR_WIDTH  read address
s_axil_arvalid  in  1  read address valid
s_axil_arready  out  1  read address ready
s_axil_rdata  out  32  read data
s_axil_rresp  out  2  read response
s_axil_rvalid  out  1  read data valid
s_axil_rready  in  1  read data ready
o_Regs  out  REG_COUNT*32  register contents; reg k occupies bits [32k+31:32k]

Behaviour:
- Reset (i_Reset low, async): all registers 0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, internal AW/W-held flags cleared. awready, wready and arready are 1 once reset is released.
- Address decode: word index = addr[ADDR_WIDTH-1:2]; addr[1:0] is ignored. Index < REG_COUNT gives OKAY (2'b00); otherwise SLVERR (2'b10).
- Write FSM has two states, WR_ACCEPT and WR_RESP.
  - WR_ACCEPT: awready = !aw_held; wready = !w_held. Each handshake latches its payload and sets its held flag.
  - The commit edge is the edge on which the second of AW/W is held; both may arrive on the same edge. On that edge the register is updated byte-wise: byte b is written iff wstrb[b]. Out-of-range indices do not update any register.
  - On the commit edge: bvalid<=1, bresp set per decode, held flags cleared, state->WR_RESP.
  - WR_RESP: awready=wready=0. bvalid and bresp are held stable until bready. On the bvalid&&bready edge: bvalid<=0, state->WR_ACCEPT.
  - Minimum write latency is 1 cycle from joint handshake to bvalid. bready asserted in advance is legal; the response then completes on the cycle bvalid rises.
- Read FSM has two states, RD_ACCEPT and RD_RESP.
  - RD_ACCEPT: arready=1. On handshake: rdata<=register (0 if out of range), rresp per decode, rvalid<=1, state->RD_RESP.
  - RD_RESP: arready=0. rdata, rresp and rvalid are held until rready. On the rvalid&&rready edge: rvalid<=0, state->RD_ACCEPT.
  - Read latency is 1 cycle.
- Read and write channels are fully independent and may be active simultaneously.
- If an AR handshake and a write commit to the same index occur on the same edge, the read returns the pre-write value.
- o_Regs reflects a write on the cycle after the commit edge.
- Reset asserted mid-transaction aborts everything immediately: pending responses are dropped and no partial write remains.
- Payload inputs are ignored when their valid is low.

Optional Feature:
Macro AXIL_REG_SLAVE_CYCLE_COUNTER_EN.
- Defined: a 32-bit free-running cycle counter is added; it resets to 0 and wraps from 0xFFFFFFFF to 0. It is readable at word index REG_COUNT with OKAY. Writes to that index return SLVERR and leave the counter unchanged. The counter is not part of o_Regs.
- Undefined: index REG_COUNT decodes as out of range (SLVERR, rdata 0).

Decomposition:
- Shared header axil.vh holds:
  - response codes AXIL_RESP_OKAY=2'b00 and AXIL_RESP_SLVERR=2'b10;
  - write/read FSM state encodings;
  - a byte-strobe merge function (old, new, strb -> merged).
- No sub-module; both channel FSMs and the register array stay flat in axil_reg_slave.

Test Plan:
- Reset, then AW and W on the same cycle: addr 0x4, data 0xDEADBEEF, strb 4'hF -> bvalid next cycle, bresp 00, o_Regs[63:32]=0xDEADBEEF; then read 0x4 -> rdata 0xDEADBEEF, rresp 00, 1-cycle latency.
- W arrives 3 cycles before AW: reg0 = 0x11223344, strb 4'b0101, data 0xAABBCCDD -> wready low after the W handshake until the response, bvalid one cycle after AW, reg0 = 0x11BB33DD.
- Out-of-range: write 0x40 with REG_COUNT=8 -> bresp 10, no register changes; read 0x40 -> rdata 0, rresp 10.
- Backpressure: hold bready/rready low for 5 cycles -> bvalid/rvalid and payloads stable, awready/wready/arready remain 0, and a new AW offered meanwhile is not accepted.
- Same-edge collision: reg2=0x5, AR to 0x8 on the write-commit edge with data 0x9 -> rdata 0x5; a subsequent read returns 0x9.
- Async reset mid-write (after AW only) and during RD_RESP -> all valids 0 immediately, registers 0. With AXIL_REG_SLAVE_CYCLE_COUNTER_EN, two reads of index 8 ten cycles apart -> values differ by 10.

Source files
------------

// File: rtl/axil_reg_slave_pkg.sv
`default_nettype none
// ============================================================================
// axil_reg_slave_pkg: response codes, channel FSM states, byte-strobe merge. Rev 1.0
// ============================================================================
package axil_reg_slave_pkg;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        WR_ACCEPT = 1'b0,
        WR_RESP   = 1'b1
    } wr_state_e;

    typedef enum logic [0:0] {
        RD_ACCEPT = 1'b0,
        RD_RESP   = 1'b1
    } rd_state_e;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_val[8*b +: 8];
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axil_reg_slave_if.sv
`default_nettype none
// ============================================================================
// axil_reg_slave_if: AXI4-Lite bus bundle (32-bit data) with master/slave views. Rev 1.0
// ============================================================================
interface axil_reg_slave_if #(
    parameter int ADDR_WIDTH = 16
) ();
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/axil_reg_slave.sv
`default_nettype none
// ============================================================================
// axil_reg_slave: AXI4-Lite RW register bank; define AXIL_REG_SLAVE_CYCLE_COUNTER_EN
// to expose a free-running cycle counter at word index REG_COUNT. Rev 1.0
// ============================================================================
module axil_reg_slave
    import axil_reg_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 8
) (
    input  logic                             i_Clock,
    input  logic                             i_Reset,
    axil_reg_slave_if.slave                  s_axil,
    output logic [REG_COUNT*DATA_WIDTH-1:0]  o_Regs
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    wr_state_e             wr_state_q, wr_state_d;
    rd_state_e             rd_state_q, rd_state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
`ifdef AXIL_REG_SLAVE_CYCLE_COUNTER_EN
    logic [31:0]           cnt_q, cnt_d;
`endif

    logic             w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_ok;
    logic [IDX_W-1:0] w_wr_idx, w_rd_idx;
    logic [31:0]      w_wr_data;
    logic [3:0]       w_wr_strb;
    logic             w_unused_addr_lsbs;

    // Byte offset within a word carries no meaning for 32-bit registers.
    assign w_unused_addr_lsbs = ^{s_axil.awaddr[1:0], s_axil.araddr[1:0]};

    assign s_axil.awready = (wr_state_q == WR_ACCEPT) && !aw_held_q;
    assign s_axil.wready  = (wr_state_q == WR_ACCEPT) && !w_held_q;
    assign s_axil.arready = (rd_state_q == RD_ACCEPT);
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rresp   = rresp_q;
    assign s_axil.rdata   = rdata_q;

    assign w_aw_hs   = s_axil.awvalid && s_axil.awready;
    assign w_w_hs    = s_axil.wvalid && s_axil.wready;
    assign w_ar_hs   = s_axil.arvalid && s_axil.arready;
    // A payload handshaking this cycle bypasses its holding register.
    assign w_wr_idx  = w_aw_hs ? s_axil.awaddr[ADDR_WIDTH-1:2] : aw_idx_q;
    assign w_wr_data = w_w_hs ? s_axil.wdata : wdata_q;
    assign w_wr_strb = w_w_hs ? s_axil.wstrb : wstrb_q;
    assign w_wr_ok   = w_wr_idx < IDX_W'(REG_COUNT);
    assign w_commit  = (aw_held_q || w_aw_hs) && (w_held_q || w_w_hs);
    assign w_rd_idx  = s_axil.araddr[ADDR_WIDTH-1:2];

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        aw_idx_d   = aw_idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        case (wr_state_q)
            WR_ACCEPT: begin
                if (w_aw_hs) begin
                    aw_held_d = 1'b1;
                    aw_idx_d  = s_axil.awaddr[ADDR_WIDTH-1:2];
                end
                if (w_w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axil.wdata;
                    wstrb_d  = s_axil.wstrb;
                end
                if (w_commit) begin
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    bvalid_d   = 1'b1;
                    bresp_d    = w_wr_ok ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
                    wr_state_d = WR_RESP;
                    for (int k = 0; k < REG_COUNT; k++) begin
                        if (w_wr_idx == IDX_W'(k))
                            regs_d[k] = strb_merge(regs_q[k], w_wr_data, w_wr_strb);
                    end
                end
            end
            WR_RESP: begin
                if (s_axil.bready) begin
                    bvalid_d   = 1'b0;
                    wr_state_d = WR_ACCEPT;
                end
            end
            default: wr_state_d = WR_ACCEPT;
        endcase
    end

    // Reads sample regs_q, so a same-edge write to the same word is not visible.
    always_comb begin
        rd_state_d = rd_state_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            RD_ACCEPT: begin
                if (w_ar_hs) begin
                    rvalid_d   = 1'b1;
                    rd_state_d = RD_RESP;
                    rdata_d    = '0;
                    rresp_d    = AXIL_RESP_SLVERR;
                    for (int k = 0; k < REG_COUNT; k++) begin
                        if (w_rd_idx == IDX_W'(k)) begin
                            rdata_d = regs_q[k];
                            rresp_d = AXIL_RESP_OKAY;
                        end
                    end
`ifdef AXIL_REG_SLAVE_CYCLE_COUNTER_EN
                    if (w_rd_idx == IDX_W'(REG_COUNT)) begin
                        rdata_d = cnt_q;
                        rresp_d = AXIL_RESP_OKAY;
                    end
`endif
                end
            end
            RD_RESP: begin
                if (s_axil.rready) begin
                    rvalid_d   = 1'b0;
                    rd_state_d = RD_ACCEPT;
                end
            end
            default: rd_state_d = RD_ACCEPT;
        endcase
    end

`ifdef AXIL_REG_SLAVE_CYCLE_COUNTER_EN
    assign cnt_d = cnt_q + 32'd1;
`endif

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            wr_state_q <= WR_ACCEPT;
            rd_state_q <= RD_ACCEPT;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= AXIL_RESP_OKAY;
            rvalid_q   <= 1'b0;
            rresp_q    <= AXIL_RESP_OKAY;
            rdata_q    <= '0;
            for (int k = 0; k < REG_COUNT; k++) regs_q[k] <= '0;
`ifdef AXIL_REG_SLAVE_CYCLE_COUNTER_EN
            cnt_q      <= '0;
`endif
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_idx_q   <= aw_idx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            regs_q     <= regs_d;
`ifdef AXIL_REG_SLAVE_CYCLE_COUNTER_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    for (genvar k = 0; k < REG_COUNT; k++) begin : g_regs
        assign o_Regs[DATA_WIDTH*k +: DATA_WIDTH] = regs_q[k];
    end

endmodule
`default_nettype wire

// File: tb/tb_axil_reg_slave.sv
`default_nettype none
// ============================================================================
// tb_axil_reg_slave: directed + randomized bench with a transaction-level model. Rev 1.0
// ============================================================================
module tb_axil_reg_slave;

`ifdef AXIL_REG_SLAVE_CYCLE_COUNTER_EN
    localparam bit HAS_CNT = 1'b1;
`else
    localparam bit HAS_CNT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] regs;
    int           checks = 0;
    int           failures = 0;

    axil_reg_slave_if #(.ADDR_WIDTH(16)) bus ();

    axil_reg_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .REG_COUNT(8)) dut (
        .i_Clock (clk),
        .i_Reset (rst_n),
        .s_axil  (bus),
        .o_Regs  (regs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [8];
    bit          m_aw, m_w, m_b, m_r;
    logic [15:0] m_awaddr;
    logic [31:0] m_wdata, m_rdata, m_cnt;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;

    function automatic logic [255:0] m_flat();
        logic [255:0] f;
        for (int k = 0; k < 8; k++) f[32*k +: 32] = m_regs[k];
        return f;
    endfunction

    always @(negedge clk) begin
        bit aw_hs, w_hs, ar_hs;
        int idx;
        logic [31:0] mask;
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) m_regs[k] = 32'h0;
            {m_aw, m_w, m_b, m_r} = 4'b0;
            m_cnt = 32'h0;
            chk("rst_bvalid", bus.bvalid, 1'b0);
            chk("rst_rvalid", bus.rvalid, 1'b0);
            chk("rst_resp", {bus.bresp, bus.rresp}, 4'h0);
            chk("rst_rdata", bus.rdata, 32'h0);
            chk("rst_regs", regs, 256'h0);
        end else begin
            chk("awready", bus.awready, !m_b && !m_aw);
            chk("wready", bus.wready, !m_b && !m_w);
            chk("arready", bus.arready, !m_r);
            chk("bvalid", bus.bvalid, m_b);
            if (m_b) chk("bresp", bus.bresp, m_bresp);
            chk("rvalid", bus.rvalid, m_r);
            if (m_r) begin
                chk("rdata", bus.rdata, m_rdata);
                chk("rresp", bus.rresp, m_rresp);
            end
            chk("o_Regs", regs, m_flat());
            // What the coming edge does, decided from the present state.
            aw_hs = bus.awvalid && !m_b && !m_aw;
            w_hs  = bus.wvalid && !m_b && !m_w;
            ar_hs = bus.arvalid && !m_r;
            if (m_r && bus.rready) m_r = 0;
            if (ar_hs) begin
                idx = int'(bus.araddr[15:2]);
                m_r = 1;
                if (idx < 8) begin
                    m_rdata = m_regs[idx]; m_rresp = 2'b00;
                end else if (HAS_CNT && idx == 8) begin
                    m_rdata = m_cnt; m_rresp = 2'b00;
                end else begin
                    m_rdata = 32'h0; m_rresp = 2'b10;
                end
            end
            if (m_b && bus.bready) m_b = 0;
            if (aw_hs) begin m_aw = 1; m_awaddr = bus.awaddr; end
            if (w_hs) begin m_w = 1; m_wdata = bus.wdata; m_wstrb = bus.wstrb; end
            if (m_aw && m_w) begin
                idx = int'(m_awaddr[15:2]);
                m_aw = 0; m_w = 0; m_b = 1;
                m_bresp = (idx < 8) ? 2'b00 : 2'b10;
                if (idx < 8) begin
                    mask = {{8{m_wstrb[3]}}, {8{m_wstrb[2]}}, {8{m_wstrb[1]}}, {8{m_wstrb[0]}}};
                    m_regs[idx] = (m_regs[idx] & ~mask) | (m_wdata & mask);
                end
            end
            m_cnt = m_cnt + 32'd1;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] resp);
        bus.awaddr = a; bus.awvalid = 1'b1;
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        bus.bready = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("wr_bvalid", bus.bvalid, 1'b1);
        resp = bus.bresp;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp);
        bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b0;
        tick();
        bus.arvalid = 1'b0;
        chk("rd_rvalid", bus.rvalid, 1'b1);
        d = bus.rdata; resp = bus.rresp;
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        a = 16'(($urandom_range(0, 9) << 2) | $urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) a = 16'($urandom);
        return a;
    endfunction

    initial begin
        logic [31:0]  d, d1, d2;
        logic [1:0]   r, r1;
        logic [255:0] snap;
        {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready} = 5'b0;
        bus.awaddr = '0; bus.araddr = '0; bus.wdata = '0; bus.wstrb = '0;
        repeat (3) tick();
        chk("reset_regs", regs, 256'h0);
        chk("reset_valids", {bus.bvalid, bus.rvalid}, 2'b00);
        rst_n = 1'b1;
        #1;
        chk("idle_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
        tick();

        // AW and W together
        bus.awaddr = 16'h4; bus.awvalid = 1'b1;
        bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("t1_bvalid", bus.bvalid, 1'b1);
        chk("t1_bresp", bus.bresp, 2'b00);
        chk("t1_reg1", regs[63:32], 32'hDEADBEEF);
        bus.bready = 1'b1; tick(); bus.bready = 1'b0;
        chk("t1_bvalid_clr", bus.bvalid, 1'b0);
        rd(16'h4, d, r);
        chk("t1_rdata", d, 32'hDEADBEEF);
        chk("t1_rresp", r, 2'b00);

        // W three cycles ahead of AW, partial strobes
        wr(16'h0, 32'h11223344, 4'hF, r);
        bus.wdata = 32'hAABBCCDD; bus.wstrb = 4'b0101; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_wready_low", bus.wready, 1'b0);
            chk("t2_no_bvalid", bus.bvalid, 1'b0);
            tick();
        end
        bus.awaddr = 16'h0; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        chk("t2_bvalid", bus.bvalid, 1'b1);
        chk("t2_reg0", regs[31:0], 32'h11BB33DD);
        bus.bready = 1'b1; tick(); bus.bready = 1'b0;

        // Out of range
        snap = regs;
        wr(16'h40, 32'hFFFFFFFF, 4'hF, r);
        chk("t3_bresp", r, 2'b10);
        chk("t3_regs_same", regs, snap);
        rd(16'h40, d, r);
        chk("t3_rdata", d, 32'h0);
        chk("t3_rresp", r, 2'b10);

        // Backpressure on both channels
        bus.awaddr = 16'h10; bus.awvalid = 1'b1;
        bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        bus.araddr = 16'h4; bus.arvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        bus.awaddr = 16'h14;
        for (int i = 0; i < 5; i++) begin
            chk("t4_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
            chk("t4_valids", {bus.bvalid, bus.rvalid}, 2'b11);
            chk("t4_rdata", bus.rdata, 32'hDEADBEEF);
            chk("t4_bresp", bus.bresp, 2'b00);
            tick();
        end
        bus.awvalid = 1'b0; bus.bready = 1'b1; bus.rready = 1'b1;
        tick();
        bus.bready = 1'b0; bus.rready = 1'b0;
        chk("t4_valids_clr", {bus.bvalid, bus.rvalid}, 2'b00);
        chk("t4_reg5_untouched", regs[191:160], 32'h0);

        // Read and write commit on the same edge
        wr(16'h8, 32'h5, 4'hF, r);
        bus.awaddr = 16'h8; bus.awvalid = 1'b1;
        bus.wdata = 32'h9; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        bus.araddr = 16'h8; bus.arvalid = 1'b1; bus.bready = 1'b1;
        tick();
        {bus.awvalid, bus.wvalid, bus.arvalid} = 3'b000;
        chk("t5_rdata_old", bus.rdata, 32'h5);
        bus.rready = 1'b1; tick(); bus.rready = 1'b0; bus.bready = 1'b0;
        rd(16'h8, d, r);
        chk("t5_rdata_new", d, 32'h9);

        // Reset with only AW held
        bus.awaddr = 16'hC; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_valids", {bus.bvalid, bus.rvalid}, 2'b00);
        chk("t6_regs", regs, 256'h0);
        tick();
        rst_n = 1'b1;
        bus.wdata = 32'h77; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        chk("t6_no_stale_aw", bus.bvalid, 1'b0);
        bus.awaddr = 16'hC; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        chk("t6_bvalid", bus.bvalid, 1'b1);
        chk("t6_reg3", regs[127:96], 32'h77);
        bus.bready = 1'b1; tick(); bus.bready = 1'b0;

        // Reset while a read response is pending
        bus.araddr = 16'hC; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        chk("t7_rvalid", bus.rvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t7_rvalid_rst", bus.rvalid, 1'b0);
        chk("t7_regs", regs, 256'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Index REG_COUNT
        rd(16'h20, d1, r1);
`ifdef AXIL_REG_SLAVE_CYCLE_COUNTER_EN
        repeat (8) tick();
        rd(16'h20, d2, r);
        chk("t8_cnt_delta", d2 - d1, 32'd10);
        chk("t8_cnt_resp", r1, 2'b00);
        wr(16'h20, 32'h0, 4'hF, r);
        chk("t8_cnt_wr_resp", r, 2'b10);
`else
        d2 = 32'h0;
        chk("t8_idx8_rdata", d1, d2);
        chk("t8_idx8_rresp", r1, 2'b10);
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            bus.awvalid = ($urandom_range(0, 2) == 0);
            bus.awaddr  = rand_addr();
            bus.wvalid  = ($urandom_range(0, 2) == 0);
            bus.wdata   = $urandom;
            bus.wstrb   = 4'($urandom);
            bus.arvalid = ($urandom_range(0, 2) == 0);
            bus.araddr  = rand_addr();
            bus.bready  = ($urandom_range(0, 3) != 0);
            bus.rready  = ($urandom_range(0, 3) != 0);
            if (c == 1500) rst_n = 1'b0;
            if (c == 1503) rst_n = 1'b1;
            tick();
        end
        {bus.awvalid, bus.wvalid, bus.arvalid} = 3'b000;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
